// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage: holds the PC, presents it to a zero-latency
//   instruction memory, and captures the returned word into the IF/ID register.
// Ports
//   clk, rst                        clock, asynchronous active-high reset
//   stall_if / stall_id / flush_id  hazard-unit controls
//   branch_taken, branch_target     ID-stage branch redirect (wins over jump)
//   jump, jump_target               ID-stage jump redirect
//   imem_addr / imem_rdata          instruction memory port (imem_addr = PC)
//   instr_id, pc_id, pc_plus4_id,   IF/ID pipeline register
//   valid_id
//   fetch_count                     instructions accepted into IF/ID
module fetch_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_if,
  input  logic                  stall_id,
  input  logic                  flush_id,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr_id,
  output logic [ADDR_WIDTH-1:0] pc_id,
  output logic [ADDR_WIDTH-1:0] pc_plus4_id,
  output logic                  valid_id,
  output logic [31:0]           fetch_count
);

  localparam logic [ADDR_WIDTH-1:0] FOUR = ADDR_WIDTH'(4);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] pc_id_q, pc_id_d;
  logic [ADDR_WIDTH-1:0] pc_plus4_id_q, pc_plus4_id_d;
  logic                  valid_q, valid_d;
  logic [31:0]           fetch_count_q, fetch_count_d;
  logic [ADDR_WIDTH-1:0] pc_plus4;

  // Natural-width add wraps the top aligned address back to zero.
  assign pc_plus4 = pc_q + FOUR;

  always_comb begin
    pc_d = pc_plus4;
    if (stall_if) begin
      pc_d = pc_q;
    end else if (branch_taken) begin
      pc_d = {branch_target[ADDR_WIDTH-1:2], 2'b00};
    end else if (jump) begin
      pc_d = {jump_target[ADDR_WIDTH-1:2], 2'b00};
    end
  end

  always_comb begin
    instr_d       = instr_q;
    pc_id_d       = pc_id_q;
    pc_plus4_id_d = pc_plus4_id_q;
    valid_d       = valid_q;
    fetch_count_d = fetch_count_q;
    // A bubble keeps the old PC fields; only the instruction and valid change.
    if (flush_id) begin
      instr_d = '0;
      valid_d = 1'b0;
    end else if (!stall_id) begin
      instr_d       = imem_rdata;
      pc_id_d       = pc_q;
      pc_plus4_id_d = pc_plus4;
      valid_d       = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      pc_id_q       <= '0;
      pc_plus4_id_q <= '0;
      valid_q       <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pc_id_q       <= pc_id_d;
      pc_plus4_id_q <= pc_plus4_id_d;
      valid_q       <= valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr_id    = instr_q;
  assign pc_id       = pc_id_q;
  assign pc_plus4_id = pc_plus4_id_q;
  assign valid_id    = valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if, stall_id, flush_id;
  logic        branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr_id, pc_id, pc_plus4_id;
  logic        valid_id;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory word k holds 0x1000_0000 + k.
  assign imem_rdata = 32'h1000_0000 + (imem_addr >> 2);

  fetch_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_id(instr_id), .pc_id(pc_id), .pc_plus4_id(pc_plus4_id),
    .valid_id(valid_id), .fetch_count(fetch_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    stall_if = 0; stall_id = 0; flush_id = 0;
    branch_taken = 0; jump = 0;
    branch_target = '0; jump_target = '0;
  endtask

  task automatic test_reset();
    clear_ctrl();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", imem_addr, 32'h0); end
    checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_id); end
    checks++; if (instr_id !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instr_id); end
    checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fetch_count); end
    rst = 0;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (imem_addr !== 32'(4*i)) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, imem_addr, 32'(4*i)); end
      checks++; if (instr_id !== 32'h1000_0000 + 32'(i-1)) begin errors++; $display("FAIL seq_instr[%0d] got %h exp %h", i, instr_id, 32'h1000_0000 + 32'(i-1)); end
      checks++; if (pc_id !== 32'(4*(i-1))) begin errors++; $display("FAIL seq_pc_id[%0d] got %h exp %h", i, pc_id, 32'(4*(i-1))); end
      checks++; if (valid_id !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %b exp 1", i, valid_id); end
      checks++; if (fetch_count !== 32'(i)) begin errors++; $display("FAIL seq_count[%0d] got %0d exp %0d", i, fetch_count, i); end
    end
  endtask

  // Enters with PC=0x14, count=5.
  task automatic test_stall();
    jump = 1; jump_target = 32'h0000_000C;
    tick();                                   // PC=0x0C, count 6
    clear_ctrl();
    tick();                                   // PC=0x10, instr=word3, count 7
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL stall_setup_pc got %h exp 10", imem_addr); end
    checks++; if (instr_id !== 32'h1000_0003) begin errors++; $display("FAIL stall_setup_instr got %h exp 10000003", instr_id); end
    stall_if = 1; stall_id = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL stall_pc[%0d] got %h exp 10", k, imem_addr); end
      checks++; if (instr_id !== 32'h1000_0003) begin errors++; $display("FAIL stall_instr[%0d] got %h exp 10000003", k, instr_id); end
      checks++; if (fetch_count !== 32'd7) begin errors++; $display("FAIL stall_count[%0d] got %0d exp 7", k, fetch_count); end
    end
    clear_ctrl();
    tick();                                   // count 8
    checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL resume_pc got %h exp 14", imem_addr); end
    checks++; if (instr_id !== 32'h1000_0004) begin errors++; $display("FAIL resume_instr got %h exp 10000004", instr_id); end
    checks++; if (pc_id !== 32'h10) begin errors++; $display("FAIL resume_pc_id got %h exp 10", pc_id); end
    checks++; if (fetch_count !== 32'd8) begin errors++; $display("FAIL resume_count got %0d exp 8", fetch_count); end
    tick();                                   // count 9
    checks++; if (instr_id !== 32'h1000_0005) begin errors++; $display("FAIL resume2_instr got %h exp 10000005", instr_id); end
  endtask

  // Enters with PC=0x18, count=9.
  task automatic test_branch_flush();
    tick(); tick();                           // PC=0x20, count 11
    checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL br_setup_pc got %h exp 20", imem_addr); end
    branch_taken = 1; branch_target = 32'h43; flush_id = 1;
    tick();
    clear_ctrl();
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL br_pc got %h exp 40", imem_addr); end
    checks++; if (instr_id !== 32'h0) begin errors++; $display("FAIL br_bubble_instr got %h exp 0", instr_id); end
    checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL br_bubble_valid got %b exp 0", valid_id); end
    checks++; if (fetch_count !== 32'd11) begin errors++; $display("FAIL br_bubble_count got %0d exp 11", fetch_count); end
    tick();                                   // count 12
    checks++; if (instr_id !== 32'h1000_0010) begin errors++; $display("FAIL br_target_instr got %h exp 10000010", instr_id); end
    checks++; if (pc_id !== 32'h40) begin errors++; $display("FAIL br_target_pc_id got %h exp 40", pc_id); end
    checks++; if (pc_plus4_id !== 32'h44) begin errors++; $display("FAIL br_target_pc4 got %h exp 44", pc_plus4_id); end
    checks++; if (valid_id !== 1'b1) begin errors++; $display("FAIL br_target_valid got %b exp 1", valid_id); end
  endtask

  // Enters with PC=0x44, pc_id=0x40, count=12.
  task automatic test_priority();
    branch_taken = 1; branch_target = 32'h100; jump = 1; jump_target = 32'h200;
    tick();                                   // count 13, pc_id=0x44
    clear_ctrl();
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL prio_br_jump got %h exp 100", imem_addr); end
    stall_id = 1; flush_id = 1;
    tick();
    clear_ctrl();
    checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL prio_flush_pc got %h exp 104", imem_addr); end
    checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL prio_flush_valid got %b exp 0", valid_id); end
    checks++; if (instr_id !== 32'h0) begin errors++; $display("FAIL prio_flush_instr got %h exp 0", instr_id); end
    checks++; if (pc_id !== 32'h44) begin errors++; $display("FAIL prio_flush_pc_id got %h exp 44", pc_id); end
    checks++; if (fetch_count !== 32'd13) begin errors++; $display("FAIL prio_flush_count got %0d exp 13", fetch_count); end
    stall_if = 1; jump = 1; jump_target = 32'h300;
    tick();                                   // IF/ID loads word 0x41, count 14
    clear_ctrl();
    checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL prio_stall_jump got %h exp 104", imem_addr); end
    checks++; if (instr_id !== 32'h1000_0041) begin errors++; $display("FAIL prio_stall_instr got %h exp 10000041", instr_id); end
    checks++; if (fetch_count !== 32'd14) begin errors++; $display("FAIL prio_stall_count got %0d exp 14", fetch_count); end
  endtask

  task automatic test_wrap();
    jump = 1; jump_target = 32'hFFFF_FFFF;   // low bits must be dropped
    tick();                                   // count 15
    clear_ctrl();
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h exp fffffffc", imem_addr); end
    tick();                                   // count 16
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_pc got %h exp 0", imem_addr); end
    checks++; if (pc_id !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc_id got %h exp fffffffc", pc_id); end
    checks++; if (pc_plus4_id !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h exp 0", pc_plus4_id); end
    checks++; if (instr_id !== 32'h4FFF_FFFF) begin errors++; $display("FAIL wrap_instr got %h exp 4fffffff", instr_id); end
    checks++; if (fetch_count !== 32'd16) begin errors++; $display("FAIL wrap_count got %0d exp 16", fetch_count); end
  endtask

  task automatic test_reset_mid_run();
    jump = 1; jump_target = 32'h80;
    tick();
    clear_ctrl();
    stall_if = 1; stall_id = 1;
    #3;
    checks++; if (imem_addr !== 32'h80) begin errors++; $display("FAIL mid_pre_pc got %h exp 80", imem_addr); end
    rst = 1;
    #1;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL mid_rst_pc got %h exp 0", imem_addr); end
    checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", valid_id); end
    checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL mid_rst_count got %0d exp 0", fetch_count); end
    tick();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL mid_rst_hold got %h exp 0", imem_addr); end
    #2;
    rst = 0;
    clear_ctrl();
    tick();
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL restart_pc got %h exp 4", imem_addr); end
    checks++; if (instr_id !== 32'h1000_0000) begin errors++; $display("FAIL restart_instr got %h exp 10000000", instr_id); end
    checks++; if (pc_id !== 32'h0) begin errors++; $display("FAIL restart_pc_id got %h exp 0", pc_id); end
    checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL restart_count got %0d exp 1", fetch_count); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_flush();
    test_priority();
    test_wrap();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
